// File: rtl/synch_unit_mt_if.sv
// synch_unit_mt_if
//
// Groups the command, completion-strobe and termination-event signals of
// synch_unit_mt. Clock and reset stay plain ports on the unit.
//
// Signals (the _i/_o suffix is as seen from synch_unit_mt):
//   cmd_req_i, cmd_sid_i, cmd_nb_i          accepted command: ID and burst count
//   tcdm_{tx,rx}_synch_req_i/_sid_i         TCDM burst-completion strobes
//   ext_{tx,rx}_synch_req_i/_sid_i          EXT burst-completion strobes
//   trans_status_o                          per-ID busy flags
//   term_o                                  per-ID one-cycle termination pulses
//   term_valid_o, term_sid_o, term_ready_i  termination-event handshake
//   err_o, err_clr_i                        sticky per-ID saturation flags and clear
//
// Modports:
//   master : the DMA control side that issues commands and strobes
//   slave  : synch_unit_mt itself

interface synch_unit_mt_if #(
    parameter int NB_TRANS        = 4,
    parameter int TRANS_SID_WIDTH = 2,
    parameter int CNT_WIDTH       = 10
);

    logic                       cmd_req_i;
    logic [TRANS_SID_WIDTH-1:0] cmd_sid_i;
    logic [CNT_WIDTH-1:0]       cmd_nb_i;

    logic                       tcdm_tx_synch_req_i;
    logic [TRANS_SID_WIDTH-1:0] tcdm_tx_synch_sid_i;
    logic                       tcdm_rx_synch_req_i;
    logic [TRANS_SID_WIDTH-1:0] tcdm_rx_synch_sid_i;

    logic                       ext_tx_synch_req_i;
    logic [TRANS_SID_WIDTH-1:0] ext_tx_synch_sid_i;
    logic                       ext_rx_synch_req_i;
    logic [TRANS_SID_WIDTH-1:0] ext_rx_synch_sid_i;

    logic [NB_TRANS-1:0]        trans_status_o;
    logic [NB_TRANS-1:0]        term_o;

    logic                       term_valid_o;
    logic [TRANS_SID_WIDTH-1:0] term_sid_o;
    logic                       term_ready_i;

    logic [NB_TRANS-1:0]        err_o;
    logic                       err_clr_i;

    modport master (
        output cmd_req_i, cmd_sid_i, cmd_nb_i,
        output tcdm_tx_synch_req_i, tcdm_tx_synch_sid_i,
        output tcdm_rx_synch_req_i, tcdm_rx_synch_sid_i,
        output ext_tx_synch_req_i, ext_tx_synch_sid_i,
        output ext_rx_synch_req_i, ext_rx_synch_sid_i,
        output term_ready_i, err_clr_i,
        input  trans_status_o, term_o, term_valid_o, term_sid_o, err_o
    );

    modport slave (
        input  cmd_req_i, cmd_sid_i, cmd_nb_i,
        input  tcdm_tx_synch_req_i, tcdm_tx_synch_sid_i,
        input  tcdm_rx_synch_req_i, tcdm_rx_synch_sid_i,
        input  ext_tx_synch_req_i, ext_tx_synch_sid_i,
        input  ext_rx_synch_req_i, ext_rx_synch_sid_i,
        input  term_ready_i, err_clr_i,
        output trans_status_o, term_o, term_valid_o, term_sid_o, err_o
    );

endinterface

// File: rtl/synch_unit_mt.sv
// synch_unit_mt
//
// Multi-transfer synchronisation unit for the DMA control path. Each of the
// NB_TRANS transfer IDs owns a TCDM-side and an EXT-side outstanding-burst
// counter. A command adds its burst count to both counters of its ID; each
// completion strobe removes one burst from the matching side. The unit
// reports per-ID busy status, per-ID termination pulses, a handshaked
// termination-event stream and sticky saturation errors.
//
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    synch_unit_mt_if.slave (commands, strobes, status, events, errors)

module synch_unit_mt #(
    parameter int NB_TRANS        = 4,
    parameter int TRANS_SID_WIDTH = 2,
    parameter int CNT_WIDTH       = 10
) (
    input  logic            clk_i,
    input  logic            rst_i,
    synch_unit_mt_if.slave  bus
);

    localparam int NW = CNT_WIDTH + 2;

    logic [CNT_WIDTH-1:0]       tcdm_cnt_q [NB_TRANS];
    logic [CNT_WIDTH-1:0]       tcdm_cnt_d [NB_TRANS];
    logic [CNT_WIDTH-1:0]       ext_cnt_q  [NB_TRANS];
    logic [CNT_WIDTH-1:0]       ext_cnt_d  [NB_TRANS];

    logic [NB_TRANS-1:0]        pending;
    logic [NB_TRANS-1:0]        pending_q;
    logic [NB_TRANS-1:0]        term_pulse;

    logic [NB_TRANS-1:0]        term_pend_q;
    logic [NB_TRANS-1:0]        term_pend_d;
    logic [NB_TRANS-1:0]        pop_mask;
    logic                       term_valid;
    logic [TRANS_SID_WIDTH-1:0] term_sid;

    logic [NB_TRANS-1:0]        err_q;
    logic [NB_TRANS-1:0]        err_d;
    logic [NB_TRANS-1:0]        err_new;

    // Returns {saturated, next_count}. The sum is formed two bits wider than
    // the counter: the top bit is the sign (underflow), and because at most
    // two full-scale values are added, the next bit down being set means the
    // result exceeded the counter range (overflow).
    function automatic logic [CNT_WIDTH:0] sat_next(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic [CNT_WIDTH-1:0] add,
        input logic                 dec_a,
        input logic                 dec_b
    );
        logic signed [NW-1:0] sum;
        sum = $signed({2'b00, cnt}) + $signed({2'b00, add})
            - $signed({{(NW-1){1'b0}}, dec_a})
            - $signed({{(NW-1){1'b0}}, dec_b});
        if (sum[NW-1]) begin
            sat_next = {1'b1, {CNT_WIDTH{1'b0}}};
        end else if (sum[CNT_WIDTH]) begin
            sat_next = {1'b1, {CNT_WIDTH{1'b1}}};
        end else begin
            sat_next = {1'b0, sum[CNT_WIDTH-1:0]};
        end
    endfunction

    // Counter update: command, tx and rx hitting one ID in the same cycle are
    // all applied together. IDs that match no tracked index are simply never
    // selected, so out-of-range sids touch no state.
    always_comb begin
        logic [CNT_WIDTH-1:0] add;
        logic [CNT_WIDTH:0]   tcdm_res;
        logic [CNT_WIDTH:0]   ext_res;
        add      = '0;
        tcdm_res = '0;
        ext_res  = '0;
        err_new  = '0;
        for (int i = 0; i < NB_TRANS; i++) begin
            add = (bus.cmd_req_i && (bus.cmd_sid_i == TRANS_SID_WIDTH'(i)))
                ? bus.cmd_nb_i : '0;
            tcdm_res = sat_next(tcdm_cnt_q[i], add,
                bus.tcdm_tx_synch_req_i && (bus.tcdm_tx_synch_sid_i == TRANS_SID_WIDTH'(i)),
                bus.tcdm_rx_synch_req_i && (bus.tcdm_rx_synch_sid_i == TRANS_SID_WIDTH'(i)));
            ext_res = sat_next(ext_cnt_q[i], add,
                bus.ext_tx_synch_req_i && (bus.ext_tx_synch_sid_i == TRANS_SID_WIDTH'(i)),
                bus.ext_rx_synch_req_i && (bus.ext_rx_synch_sid_i == TRANS_SID_WIDTH'(i)));
            tcdm_cnt_d[i] = tcdm_res[CNT_WIDTH-1:0];
            ext_cnt_d[i]  = ext_res[CNT_WIDTH-1:0];
            err_new[i]    = tcdm_res[CNT_WIDTH] | ext_res[CNT_WIDTH];
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < NB_TRANS; i++) begin
            pending[i] = (tcdm_cnt_q[i] != '0) || (ext_cnt_q[i] != '0);
        end
    end

    assign term_pulse = ~pending & pending_q;

    // Event stream presents the lowest pending ID. Scanning downward lets the
    // last (lowest) set bit win.
    always_comb begin
        term_sid = '0;
        for (int i = NB_TRANS - 1; i >= 0; i--) begin
            if (term_pend_q[i]) begin
                term_sid = TRANS_SID_WIDTH'(i);
            end
        end
    end

    assign term_valid = |term_pend_q;

    // A fresh termination is ORed in after the pop, so a pulse arriving on the
    // edge its bit is consumed keeps the bit set; repeats coalesce.
    always_comb begin
        pop_mask = '0;
        if (term_valid && bus.term_ready_i) begin
            pop_mask[term_sid] = 1'b1;
        end
        term_pend_d = (term_pend_q & ~pop_mask) | term_pulse;
    end

    // A new saturation on an ID beats a same-cycle clear for that ID.
    always_comb begin
        err_d = (bus.err_clr_i ? '0 : err_q) | err_new;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NB_TRANS; i++) begin
                tcdm_cnt_q[i] <= '0;
                ext_cnt_q[i]  <= '0;
            end
            pending_q   <= '0;
            term_pend_q <= '0;
            err_q       <= '0;
        end else begin
            for (int i = 0; i < NB_TRANS; i++) begin
                tcdm_cnt_q[i] <= tcdm_cnt_d[i];
                ext_cnt_q[i]  <= ext_cnt_d[i];
            end
            pending_q   <= pending;
            term_pend_q <= term_pend_d;
            err_q       <= err_d;
        end
    end

    // Outputs are forced low while reset is asserted so nothing stale is
    // visible before the first reset edge has cleared the registers.
    assign bus.trans_status_o = rst_i ? '0   : (pending | pending_q);
    assign bus.term_o         = rst_i ? '0   : term_pulse;
    assign bus.term_valid_o   = rst_i ? 1'b0 : term_valid;
    assign bus.term_sid_o     = rst_i ? '0   : term_sid;
    assign bus.err_o          = rst_i ? '0   : err_q;

endmodule
